// File: rtl/w460_core.sv
// w460_core: parametrised five-state multicycle accumulator-style core.
// Define W460_INDIRECT_EN to enable the r0-indirect operand and memory write-back.
module w460_core #(
    parameter int N  = 8,
    parameter int RW = 2
) (
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] mem_rd_addr1,
    input  logic [N-1:0] mem_rd_data1,
    output logic [N-1:0] mem_rd_addr2,
    input  logic [N-1:0] mem_rd_data2,
    output logic [N-1:0] mem_wr_addr,
    output logic [N-1:0] mem_wr_data,
    output logic         mem_wr_en,
    output logic         instr_done
);

`ifdef W460_INDIRECT_EN
    localparam bit IND = 1'b1;
`else
    localparam bit IND = 1'b0;
`endif

    localparam int NR = 2**RW;

    typedef enum logic [2:0] {
        S_IF, S_ID, S_OP, S_EX, S_WB
    } state_t;

    state_t state, state_nx;

    logic [N-1:0] pc;
    logic [N-1:0] ir;
    logic [N-1:0] result;
    logic [N-1:0] regs [NR];
    logic         wr_q;
    logic         done_q;

    logic [2:0]    opc;
    logic [RW-1:0] reg1;
    logic [RW-1:0] reg0;
    logic          dst;

    assign opc  = ir[N-1 -: 3];
    assign reg1 = ir[N-4 -: RW];
    assign reg0 = ir[N-4-RW -: RW];
    assign dst  = ir[0];

    logic         is_branch;
    logic         two_word;
    logic         indirect;
    logic         mem_wb;
    logic         taken;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic [N-1:0] opr;
    logic [N-1:0] alu;
    logic [N-1:0] target;

    // odd opcodes carry an immediate; beq/blt carry an offset
    assign is_branch = opc[2] & opc[1];
    assign two_word  = opc[0] | is_branch;
    assign indirect  = IND && (reg0 == '0);
    assign mem_wb    = indirect && !dst && !opc[0] && !is_branch;

    assign opb = regs[reg1];
    assign opr = regs[reg0];
    assign opa = two_word ? mem_rd_data1
               : (indirect ? mem_rd_data2 : opr);

    assign taken  = opc[0] ? (opb < opr) : (opb == opr);
    // pc already points one past the opcode word here
    assign target = pc + mem_rd_data1 - N'(1);

    always_comb begin
        alu = opb;
        unique case (opc[2:1])
            2'b00:   alu = opb + opa;
            2'b01:   alu = opb - opa;
            2'b10:   alu = (dst || opc[0]) ? opa : opb;
            default: alu = opb;
        endcase
    end

    always_comb begin
        state_nx = S_IF;
        case (state)
            S_IF:    state_nx = S_ID;
            S_ID:    state_nx = S_OP;
            S_OP:    state_nx = S_EX;
            S_EX:    state_nx = S_WB;
            default: state_nx = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IF;
            pc     <= '0;
            ir     <= '0;
            result <= '0;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            for (int i = 0; i < NR; i++) regs[i] <= '0;
        end else begin
            state  <= state_nx;
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            case (state)
                S_ID: begin
                    ir <= mem_rd_data1;
                    pc <= pc + N'(1);
                end
                S_EX: begin
                    result <= alu;
                    wr_q   <= mem_wb;
                    done_q <= 1'b1;
                    if (is_branch && taken) pc <= target;
                    else if (two_word) pc <= pc + N'(1);
                end
                S_WB: begin
                    if (!is_branch && !mem_wb)
                        regs[dst ? reg1 : reg0] <= result;
                end
                default: ;
            endcase
        end
    end

    assign mem_rd_addr1 = pc;
    assign mem_rd_addr2 = IND ? regs[0] : '0;
    assign mem_wr_addr  = regs[0];
    assign mem_wr_data  = result;
    assign mem_wr_en    = IND & wr_q;
    assign instr_done   = done_q;

endmodule

// File: tb/tb_w460_core.sv
// tb_w460_core: scoreboard bench for w460_core against an ISA-level model.
// Honours W460_INDIRECT_EN the same way the core does.
module tb_w460_core;
    localparam int N  = 8;
    localparam int RW = 2;
`ifdef W460_INDIRECT_EN
    localparam bit IND = 1'b1;
`else
    localparam bit IND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] a1, d1, a2, d2, wa, wd;
    logic       we, done;

    w460_core #(.N(N), .RW(RW)) dut (
        .clk(clk),
        .reset(reset),
        .mem_rd_addr1(a1),
        .mem_rd_data1(d1),
        .mem_rd_addr2(a2),
        .mem_rd_data2(d2),
        .mem_wr_addr(wa),
        .mem_wr_data(wd),
        .mem_wr_en(we),
        .instr_done(done)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] img [256];

    always @(posedge clk) begin
        d1 <= mem[a1];
        d2 <= mem[a2];
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= img[i];
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    typedef struct packed {
        logic [7:0] npc;
        logic [7:0] r0;
        logic [7:0] res;
        logic       chk_res;
        logic       wr;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // instruction-level model: executes k instructions from img
    task automatic model_run(input int k);
        logic [7:0] m [256];
        logic [7:0] r [4];
        logic [7:0] pc, w, imm, opa, opb, res;
        logic [2:0] op;
        logic [1:0] ra, rb;
        logic       d, two, ind, tk;
        exp_t       e;
        m  = img;
        pc = 8'h00;
        for (int i = 0; i < 4; i++) r[i] = 8'h00;
        repeat (k) begin
            w   = m[pc];
            imm = m[pc + 8'd1];
            op  = w[7:5];
            ra  = w[4:3];
            rb  = w[2:1];
            d   = w[0];
            two = op inside {3'd1, 3'd3, 3'd5, 3'd6, 3'd7};
            ind = IND && (rb == 2'd0);
            opb = r[ra];
            opa = two ? imm : (ind ? m[r[0]] : r[rb]);
            case (op)
                3'd0, 3'd1: res = opb + opa;
                3'd2, 3'd3: res = opb - opa;
                3'd4:       res = d ? opa : opb;
                3'd5:       res = imm;
                default:    res = 8'h00;
            endcase
            e.r0      = r[0];
            e.res     = res;
            e.wr      = 1'b0;
            e.chk_res = 1'b1;
            if (op >= 3'd6) begin
                e.chk_res = 1'b0;
                tk = (op == 3'd6) ? (r[ra] == r[rb]) : (r[ra] < r[rb]);
                pc = tk ? pc + imm : pc + 8'd2;
            end else begin
                pc = pc + (two ? 8'd2 : 8'd1);
                if (ind && !d && op inside {3'd0, 3'd2, 3'd4}) begin
                    m[r[0]] = res;
                    e.wr = 1'b1;
                end else if (d) begin
                    r[ra] = res;
                end else begin
                    r[rb] = res;
                end
            end
            e.npc = pc;
            q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
        end else begin
            cyc++;
            if (done) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done at pc %h expected none", a1);
                end else begin
                    e_m = q.pop_front();
                    chk("latency", 8'(cyc), 8'd5);
                    chk("next_pc", a1, e_m.npc);
                    chk("wr_en", 8'(we), 8'(e_m.wr));
                    chk("wr_addr", wa, e_m.r0);
                    chk("rd_addr2", a2, IND ? e_m.r0 : 8'h00);
                    if (e_m.chk_res) chk("result", wd, e_m.res);
                end
                cyc = 0;
            end else if (we) begin
                tests++;
                fails++;
                $display("FAIL stray_wr: got wr_en=1 expected 0 outside WB");
            end
        end
    end

    task automatic load_img();
        @(posedge clk);
        #1 load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic run_round(input int k);
        int c;
        reset = 1'b1;
        q.delete();
        load_img();
        @(negedge clk);
        chk("rst_addr1", a1, 8'h00);
        chk("rst_addr2", a2, 8'h00);
        chk("rst_wr_addr", wa, 8'h00);
        chk("rst_wr_data", wd, 8'h00);
        chk("rst_wr_en", 8'(we), 8'h00);
        chk("rst_done", 8'(done), 8'h00);
        model_run(k);
        @(posedge clk);
        #1 reset = 1'b0;
        c = 0;
        while (q.size() > 0 && c < k * 6 + 20) begin
            @(posedge clk);
            c++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d pending expected 0", q.size());
        end
        #1 reset = 1'b1;
    endtask

    task automatic abort_then_movi();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[0]    = 8'h09;
        img[8'h10] = 8'h07;
        reset = 1'b1;
        q.delete();
        load_img();
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[0] = 8'hA9;
        img[1] = 8'h05;
        run_round(1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        abort_then_movi();

        for (int i = 0; i < 256; i++) img[i] = 8'h00;
        img[8'h00] = 8'hA9; img[8'h01] = 8'h05;
        img[8'h02] = 8'hA1; img[8'h03] = 8'h10;
        img[8'h04] = 8'hA9; img[8'h05] = 8'h03;
        img[8'h06] = 8'h09; img[8'h07] = 8'h08;
        img[8'h08] = 8'hB1; img[8'h09] = 8'h01;
        img[8'h0A] = 8'h74; img[8'h0B] = 8'h03;
        img[8'h0C] = 8'hEC; img[8'h0D] = 8'h10;
        img[8'h10] = 8'h07;
        img[8'h19] = 8'h88;
        img[8'h1A] = 8'hC0; img[8'h1B] = 8'hE5;
        img[8'h1C] = 8'hCA; img[8'h1D] = 8'hFD;
        img[8'hFF] = 8'h9A;
        run_round(16);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
            run_round(40);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
